xcorr_peak_sequencer: RTL and testbench
=======================================

Name: xcorr_peak_sequencer

Overview:
- Frame controller for the cross-channel spectral product stage.
- Joins two AXI-Stream FFT output channels (X and Y) bin-by-bin and feeds each bin pair to the complex multiplier datapath.
- Tracks bin index and tlast alignment, and searches a configurable bin window for the largest product magnitude.
- Reports one peak result per FFT frame to the bearing-estimation logic over a valid/ready handshake.

Parameters:
- FFT_LEN, 1024, bins per frame (power of two).
- BIN_W, $clog2(FFT_LEN), bin index width.
- MULT_LAT, 1, cycles from mult_in_valid to matching mult_result (≥1).
- RES_W, 47, multiplier result width.

Ports:
- clk  in  1  clock
- reset_b  in  1  reset
- enable  in  1  allow next frame to start
- cfg_bin_lo  in  BIN_W  first bin of search window (inclusive)
- cfg_bin_hi  in  BIN_W  last bin of search window (inclusive)
- s_x_tdata  in  32  X bin, re[10:0], im[26:16]
- s_x_tvalid / s_x_tlast  in  1 each
- s_x_tready  out  1
- s_y_tdata  in  32  Y bin, same format
- s_y_tvalid / s_y_tlast  in  1 each
- s_y_tready  out  1
- mult_x_data  out  32  registered X bin to multiplier
- mult_y_data  out  32  registered Y bin to multiplier
- mult_in_valid  out  1  pulse: new pair on mult_*_data
- mult_result  in  RES_W  unsigned magnitude, MULT_LAT after mult_in_valid
- peak_valid  out  1  report available
- peak_ready  in  1  report consumed
- peak_bin  out  BIN_W  winning bin index
- peak_mag  out  RES_W  winning magnitude
- peak_found  out  1  at least one bin fell in window
- frame_err  out  1  tlast misalignment this frame
- frame_cnt  out  16  completed frames, wraps at 65535→0
- busy  out  1  state ≠ IDLE

Behaviour:
- Reset: reset_b is asynchronous, active-low; clock is clk. All outputs 0 on reset, state IDLE; all counters, the pipeline and the peak registers are cleared. Reset mid-frame discards the frame with no report.
- States:
  - IDLE: when enable=1, latch cfg_bin_lo/hi, clear bin counter, peak registers and error; go to RUN next cycle.
  - RUN: fire = s_x_tvalid & s_y_tvalid; s_x_tready = s_y_tready = fire (both or neither accepted; no lone-channel handshake). Leave RUN on the fire that is the frame's last bin; go to DRAIN.
  - DRAIN: wait until the last bin's result has been evaluated (exactly MULT_LAT cycles after its mult_in_valid); go to REPORT.
  - REPORT: peak_valid=1, outputs stable until peak_valid&peak_ready. On that cycle frame_cnt increments and state returns to IDLE. Outside RUN both treadys are 0.
- Datapath drive: on fire, mult_x_data/mult_y_data register the inputs and mult_in_valid pulses the next cycle. Data holds when no fire. Throughput is one bin per cycle.
- Alignment: a MULT_LAT-deep shift register carries valid and bin index alongside the multiplier; mult_result is sampled only when the delayed valid is set.
- Bin counter: increments per fire, from 0.
  - Last bin = the fire where either tlast=1, or the counter = FFT_LEN-1.
  - frame_err is set if s_x_tlast≠s_y_tlast on any fire, if tlast arrives before FFT_LEN-1, or if tlast is absent at FFT_LEN-1.
  - frame_err is sticky until the next IDLE→RUN.
- Peak search: a bin qualifies if lo ≤ idx ≤ hi (unsigned compare).
  - The first qualifying bin always loads peak_mag/peak_bin and sets peak_found.
  - Later bins replace only on strictly greater magnitude, so ties keep the lowest index.
  - lo>hi, or no qualifying bin: peak_found=0, peak_mag=0, peak_bin=cfg_bin_lo latched.
- enable is sampled only in IDLE; deassertion mid-frame does not abort. cfg changes outside IDLE are ignored.

Decomposition:
- Shared package xcorr_pkg: FFT_LEN/BIN_W/RES_W constants, bin field offsets (re [10:0], im [26:16]), state enum {IDLE,RUN,DRAIN,REPORT}.
- One sub-module: xcorr_valid_delay (parameterised shift register carrying valid+bin index, depth MULT_LAT).
- The multiplier itself is external.

Test Plan:
- FFT_LEN=8, window 0..7; both streams continuous, mult model returns 10·idx; tlast on bin 7 → peak_bin=7, peak_mag=70, peak_found=1, frame_err=0, frame_cnt=1.
- Magnitudes {5,9,9,3,…}, window 0..7 → peak_bin=1 (tie keeps lowest), peak_mag=9.
- Window 3..4, bin 6 largest → peak_bin picks max of bins 3,4 only. Window lo=5,hi=2 → peak_found=0, peak_mag=0, peak_bin=5.
- Y tvalid lags X by 3 cycles, random gaps → treadys never differ; mult_in_valid count=8; results identical to gap-free run.
- X tlast at bin 7, Y tlast at bin 5 → frame ends at bin 5, frame_err=1; peak_ready held low 4 cycles → outputs stable, both treadys 0.
- Assert reset_b low at bin 4 → all outputs 0 immediately; next frame after release reports normally with frame_cnt=1.

Source files
------------

// File: rtl/xcorr_pkg.sv
// Shared constants, bin field layout and controller states for the
// cross-channel spectral product frame controller.
package xcorr_pkg;

    localparam int DEF_FFT_LEN = 1024;
    localparam int DEF_RES_W   = 47;

    localparam int RE_LSB = 0;
    localparam int RE_MSB = 10;
    localparam int IM_LSB = 16;
    localparam int IM_MSB = 26;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        REPORT
    } state_t;

endpackage

// File: rtl/xcorr_valid_delay.sv
// Shift register carrying a valid flag and bin index alongside the
// external multiplier so results can be tagged with their bin.
module xcorr_valid_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic         in_valid,
    input  logic [W-1:0] in_bin,
    output logic         out_valid,
    output logic [W-1:0] out_bin
);

    logic [DEPTH-1:0] vld;
    logic [W-1:0]     bin [DEPTH];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bin[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            bin[0] <= in_bin;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                bin[i] <= bin[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_bin   = bin[DEPTH-1];

endmodule

// File: rtl/xcorr_peak_sequencer.sv
// Joins X/Y FFT bin streams, drives the external multiplier and reports
// the largest in-window product magnitude once per frame.
module xcorr_peak_sequencer
    import xcorr_pkg::*;
#(
    parameter int FFT_LEN  = DEF_FFT_LEN,
    parameter int BIN_W    = $clog2(FFT_LEN),
    parameter int MULT_LAT = 1,
    parameter int RES_W    = DEF_RES_W
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             enable,
    input  logic [BIN_W-1:0] cfg_bin_lo,
    input  logic [BIN_W-1:0] cfg_bin_hi,
    input  logic [31:0]      s_x_tdata,
    input  logic             s_x_tvalid,
    input  logic             s_x_tlast,
    output logic             s_x_tready,
    input  logic [31:0]      s_y_tdata,
    input  logic             s_y_tvalid,
    input  logic             s_y_tlast,
    output logic             s_y_tready,
    output logic [31:0]      mult_x_data,
    output logic [31:0]      mult_y_data,
    output logic             mult_in_valid,
    input  logic [RES_W-1:0] mult_result,
    output logic             peak_valid,
    input  logic             peak_ready,
    output logic [BIN_W-1:0] peak_bin,
    output logic [RES_W-1:0] peak_mag,
    output logic             peak_found,
    output logic             frame_err,
    output logic [15:0]      frame_cnt,
    output logic             busy
);

    localparam logic [BIN_W-1:0] BIN_MAX = BIN_W'(FFT_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [BIN_W-1:0] lo_q;
    logic [BIN_W-1:0] hi_q;
    logic [BIN_W-1:0] bin_cnt;
    logic [BIN_W-1:0] mult_bin;
    logic [BIN_W-1:0] d_bin;
    logic [7:0]       drain_cnt;
    logic             d_valid;
    logic             start;
    logic             fire;
    logic             tlast_any;
    logic             at_end;
    logic             last_fire;
    logic             err_now;
    logic             drain_done;
    logic             qual;
    logic             take;

    // Both channels are accepted together or not at all.
    assign fire       = (state == RUN) & s_x_tvalid & s_y_tvalid;
    assign s_x_tready = fire;
    assign s_y_tready = fire;

    assign start      = (state == IDLE) & enable;
    assign tlast_any  = s_x_tlast | s_y_tlast;
    assign at_end     = (bin_cnt == BIN_MAX);
    assign last_fire  = fire & (tlast_any | at_end);
    assign err_now    = (s_x_tlast ^ s_y_tlast) | (tlast_any ^ at_end);
    assign drain_done = (drain_cnt == 8'(MULT_LAT));

    assign qual = d_valid & (d_bin >= lo_q) & (d_bin <= hi_q);
    assign take = qual & (!peak_found | (mult_result > peak_mag));

    always_comb begin
        state_nxt  = state;
        peak_valid = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                if (last_fire) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_done) state_nxt = REPORT;
            end
            REPORT: begin
                peak_valid = 1'b1;
                if (peak_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            lo_q      <= '0;
            hi_q      <= '0;
            bin_cnt   <= '0;
            frame_err <= 1'b0;
            drain_cnt <= '0;
            frame_cnt <= '0;
        end else begin
            if (start) begin
                lo_q      <= cfg_bin_lo;
                hi_q      <= cfg_bin_hi;
                bin_cnt   <= '0;
                frame_err <= 1'b0;
            end
            if (fire) begin
                bin_cnt <= bin_cnt + 1'b1;
                if (err_now) frame_err <= 1'b1;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 8'd1 : 8'd0;
            if (peak_valid & peak_ready) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mult_x_data   <= '0;
            mult_y_data   <= '0;
            mult_bin      <= '0;
            mult_in_valid <= 1'b0;
        end else begin
            mult_in_valid <= fire;
            if (fire) begin
                mult_x_data <= s_x_tdata;
                mult_y_data <= s_y_tdata;
                mult_bin    <= bin_cnt;
            end
        end
    end

    // An empty window leaves the report at lo with zero magnitude.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            peak_bin   <= '0;
            peak_mag   <= '0;
            peak_found <= 1'b0;
        end else if (start) begin
            peak_bin   <= cfg_bin_lo;
            peak_mag   <= '0;
            peak_found <= 1'b0;
        end else if (take) begin
            peak_bin   <= d_bin;
            peak_mag   <= mult_result;
            peak_found <= 1'b1;
        end
    end

    xcorr_valid_delay #(
        .DEPTH(MULT_LAT),
        .W    (BIN_W)
    ) u_dly (
        .clk      (clk),
        .reset_b  (reset_b),
        .in_valid (mult_in_valid),
        .in_bin   (mult_bin),
        .out_valid(d_valid),
        .out_bin  (d_bin)
    );

endmodule

// File: tb/tb_xcorr_peak_sequencer.sv
// Directed bench for xcorr_peak_sequencer with a small FFT and an
// adder-based multiplier model of configurable latency.
module tb_xcorr_peak_sequencer;

    localparam int FFT_LEN  = 8;
    localparam int BIN_W    = 3;
    localparam int MULT_LAT = 2;
    localparam int RES_W    = 47;

    logic             clk = 1'b0;
    logic             reset_b = 1'b0;
    logic             enable = 1'b0;
    logic [BIN_W-1:0] cfg_bin_lo = '0;
    logic [BIN_W-1:0] cfg_bin_hi = '0;
    logic [31:0]      s_x_tdata = '0;
    logic             s_x_tvalid = 1'b0;
    logic             s_x_tlast = 1'b0;
    logic             s_x_tready;
    logic [31:0]      s_y_tdata = '0;
    logic             s_y_tvalid = 1'b0;
    logic             s_y_tlast = 1'b0;
    logic             s_y_tready;
    logic [31:0]      mult_x_data;
    logic [31:0]      mult_y_data;
    logic             mult_in_valid;
    logic [RES_W-1:0] mult_result;
    logic             peak_valid;
    logic             peak_ready = 1'b0;
    logic [BIN_W-1:0] peak_bin;
    logic [RES_W-1:0] peak_mag;
    logic             peak_found;
    logic             frame_err;
    logic [15:0]      frame_cnt;
    logic             busy;

    int compared = 0;
    int mismatched = 0;
    int mag [FFT_LEN];
    int xlast_at;
    int ylast_at;
    int mcount = 0;

    logic [RES_W-1:0] mpipe [MULT_LAT];

    always #5 clk = ~clk;

    // Multiplier model: magnitude = X.re + Y.re, MULT_LAT cycles later.
    always @(posedge clk) begin
        mpipe[0] <= mult_in_valid
            ? RES_W'(mult_x_data[10:0]) + RES_W'(mult_y_data[10:0])
            : '0;
        for (int k = 1; k < MULT_LAT; k++) mpipe[k] <= mpipe[k-1];
        if (mult_in_valid) mcount++;
    end
    assign mult_result = mpipe[MULT_LAT-1];

    xcorr_peak_sequencer #(
        .FFT_LEN (FFT_LEN),
        .BIN_W   (BIN_W),
        .MULT_LAT(MULT_LAT),
        .RES_W   (RES_W)
    ) dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .enable       (enable),
        .cfg_bin_lo   (cfg_bin_lo),
        .cfg_bin_hi   (cfg_bin_hi),
        .s_x_tdata    (s_x_tdata),
        .s_x_tvalid   (s_x_tvalid),
        .s_x_tlast    (s_x_tlast),
        .s_x_tready   (s_x_tready),
        .s_y_tdata    (s_y_tdata),
        .s_y_tvalid   (s_y_tvalid),
        .s_y_tlast    (s_y_tlast),
        .s_y_tready   (s_y_tready),
        .mult_x_data  (mult_x_data),
        .mult_y_data  (mult_y_data),
        .mult_in_valid(mult_in_valid),
        .mult_result  (mult_result),
        .peak_valid   (peak_valid),
        .peak_ready   (peak_ready),
        .peak_bin     (peak_bin),
        .peak_mag     (peak_mag),
        .peak_found   (peak_found),
        .frame_err    (frame_err),
        .frame_cnt    (frame_cnt),
        .busy         (busy)
    );

    function automatic logic [31:0] bin_word(input int re, input int im);
        logic [10:0] r;
        logic [10:0] m;
        r = 11'(re);
        m = 11'(im);
        return {5'd0, m, 5'd0, r};
    endfunction

    function automatic logic [31:0] x_word(input int i);
        return bin_word(mag[i] / 2, i);
    endfunction

    function automatic logic [31:0] y_word(input int i);
        return bin_word(mag[i] - mag[i] / 2, i + 1);
    endfunction

    // Streams one frame; cfg is scrambled once RUN starts to prove latching.
    task automatic run_frame(input int lo, input int hi, input int ylag,
                             input bit gaps, output int fires,
                             output int skew);
        int  i;
        int  cyc;
        bit  xv;
        bit  yv;
        bit  f;
        bit  done;
        fires = 0;
        skew  = 0;
        i     = 0;
        cyc   = 0;
        xv    = 1'b0;
        yv    = 1'b0;
        done  = 1'b0;
        mcount = 0;
        cfg_bin_lo = BIN_W'(lo);
        cfg_bin_hi = BIN_W'(hi);
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        cfg_bin_lo = BIN_W'(hi);
        cfg_bin_hi = BIN_W'(lo);
        while (!done && cyc < 200) begin
            if (!xv) xv = !gaps || ($urandom_range(0, 2) != 0);
            if (!yv) yv = (cyc >= ylag) &&
                          (!gaps || ($urandom_range(0, 2) != 0));
            s_x_tvalid = xv;
            s_y_tvalid = yv;
            s_x_tdata  = x_word(i);
            s_y_tdata  = y_word(i);
            s_x_tlast  = (i == xlast_at);
            s_y_tlast  = (i == ylast_at);
            @(negedge clk);
            if (s_x_tready !== s_y_tready) skew++;
            if (s_x_tready !== (xv & yv)) skew++;
            f = s_x_tready;
            @(posedge clk); #1;
            cyc++;
            if (f) begin
                fires++;
                if (i == FFT_LEN - 1 || i == xlast_at || i == ylast_at)
                    done = 1'b1;
                i++;
                xv = 1'b0;
                yv = 1'b0;
            end
        end
        s_x_tvalid = 1'b0;
        s_y_tvalid = 1'b0;
        s_x_tlast  = 1'b0;
        s_y_tlast  = 1'b0;
    endtask

    task automatic wait_report(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            seen = peak_valid;
        end
    endtask

    task automatic ack_report();
        peak_ready = 1'b1;
        @(posedge clk); #1;
        peak_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_ramp();
        for (int k = 0; k < FFT_LEN; k++) mag[k] = 10 * k;
    endtask

    task automatic test_reset();
        s_x_tvalid = 1'b1;
        s_y_tvalid = 1'b1;
        @(negedge clk);
        compared++;
        if ({busy, peak_valid, mult_in_valid, peak_found, frame_err,
             s_x_tready, s_y_tready} !== 7'd0 || frame_cnt !== 16'd0 ||
            peak_mag !== '0 || peak_bin !== '0 || mult_x_data !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got busy=%0b cnt=%0d mag=%0d want 0",
                     busy, frame_cnt, peak_mag);
        end
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({busy, s_x_tready, s_y_tready} !== 3'd0) begin
            mismatched++;
            $display("FAIL idle_no_enable: got busy/rdy=%b want 000",
                     {busy, s_x_tready, s_y_tready});
        end
        s_x_tvalid = 1'b0;
        s_y_tvalid = 1'b0;
    endtask

    task automatic test_basic();
        int fires;
        int skew;
        bit seen;
        set_ramp();
        xlast_at = 7;
        ylast_at = 7;
        run_frame(0, 7, 0, 1'b0, fires, skew);
        wait_report(seen);
        compared++;
        if (seen !== 1'b1 || peak_bin !== 3'd7 || peak_mag !== RES_W'(70)) begin
            mismatched++;
            $display("FAIL basic_peak: got v=%0b bin=%0d mag=%0d want 1/7/70",
                     seen, peak_bin, peak_mag);
        end
        compared++;
        if (peak_found !== 1'b1 || frame_err !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_flags: got found=%0b err=%0b want 1/0",
                     peak_found, frame_err);
        end
        compared++;
        if (mcount !== 8 || fires !== 8) begin
            mismatched++;
            $display("FAIL basic_count: got mult=%0d fires=%0d want 8/8",
                     mcount, fires);
        end
        ack_report();
        compared++;
        if (frame_cnt !== 16'd1 || peak_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_ack: got cnt=%0d v=%0b busy=%0b want 1/0/0",
                     frame_cnt, peak_valid, busy);
        end
    endtask

    task automatic test_tie();
        int fires;
        int skew;
        bit seen;
        int t [FFT_LEN] = '{5, 9, 9, 3, 1, 2, 0, 4};
        mag = t;
        xlast_at = 7;
        ylast_at = 7;
        run_frame(0, 7, 0, 1'b0, fires, skew);
        wait_report(seen);
        compared++;
        if (seen !== 1'b1 || peak_bin !== 3'd1 || peak_mag !== RES_W'(9)) begin
            mismatched++;
            $display("FAIL tie_peak: got v=%0b bin=%0d mag=%0d want 1/1/9",
                     seen, peak_bin, peak_mag);
        end
        ack_report();
        compared++;
        if (frame_cnt !== 16'd2) begin
            mismatched++;
            $display("FAIL tie_cnt: got %0d want 2", frame_cnt);
        end
    endtask

    task automatic test_window();
        int fires;
        int skew;
        bit seen;
        int t [FFT_LEN] = '{1, 2, 3, 6, 7, 5, 50, 4};
        mag = t;
        xlast_at = 7;
        ylast_at = 7;
        run_frame(3, 4, 0, 1'b0, fires, skew);
        wait_report(seen);
        compared++;
        if (seen !== 1'b1 || peak_bin !== 3'd4 || peak_mag !== RES_W'(7) ||
            peak_found !== 1'b1) begin
            mismatched++;
            $display("FAIL window_peak: got bin=%0d mag=%0d f=%0b want 4/7/1",
                     peak_bin, peak_mag, peak_found);
        end
        ack_report();
        set_ramp();
        run_frame(5, 2, 0, 1'b0, fires, skew);
        wait_report(seen);
        compared++;
        if (seen !== 1'b1 || peak_bin !== 3'd5 || peak_mag !== '0 ||
            peak_found !== 1'b0) begin
            mismatched++;
            $display("FAIL window_empty: got bin=%0d mag=%0d f=%0b want 5/0/0",
                     peak_bin, peak_mag, peak_found);
        end
        ack_report();
        compared++;
        if (frame_cnt !== 16'd4) begin
            mismatched++;
            $display("FAIL window_cnt: got %0d want 4", frame_cnt);
        end
    endtask

    task automatic test_gaps();
        int fires;
        int skew;
        bit seen;
        set_ramp();
        xlast_at = 7;
        ylast_at = 7;
        run_frame(0, 7, 3, 1'b1, fires, skew);
        compared++;
        if (skew !== 0) begin
            mismatched++;
            $display("FAIL gaps_ready: got %0d skewed cycles want 0", skew);
        end
        wait_report(seen);
        compared++;
        if (seen !== 1'b1 || peak_bin !== 3'd7 || peak_mag !== RES_W'(70) ||
            frame_err !== 1'b0) begin
            mismatched++;
            $display("FAIL gaps_peak: got bin=%0d mag=%0d err=%0b want 7/70/0",
                     peak_bin, peak_mag, frame_err);
        end
        compared++;
        if (mcount !== 8) begin
            mismatched++;
            $display("FAIL gaps_mult: got %0d want 8", mcount);
        end
        ack_report();
    endtask

    task automatic test_misalign();
        int fires;
        int skew;
        int bad;
        bit seen;
        set_ramp();
        xlast_at = 7;
        ylast_at = 5;
        run_frame(0, 7, 0, 1'b0, fires, skew);
        wait_report(seen);
        compared++;
        if (seen !== 1'b1 || fires !== 6 || peak_bin !== 3'd5 ||
            peak_mag !== RES_W'(50) || frame_err !== 1'b1) begin
            mismatched++;
            $display("FAIL misalign_peak: got n=%0d bin=%0d mag=%0d err=%0b want 6/5/50/1",
                     fires, peak_bin, peak_mag, frame_err);
        end
        bad = 0;
        s_x_tvalid = 1'b1;
        s_y_tvalid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (peak_valid !== 1'b1 || peak_bin !== 3'd5 ||
                peak_mag !== RES_W'(50) || frame_err !== 1'b1 ||
                s_x_tready !== 1'b0 || s_y_tready !== 1'b0) bad++;
        end
        s_x_tvalid = 1'b0;
        s_y_tvalid = 1'b0;
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL misalign_hold: got %0d unstable cycles want 0", bad);
        end
        ack_report();
        compared++;
        if (frame_cnt !== 16'd6) begin
            mismatched++;
            $display("FAIL misalign_cnt: got %0d want 6", frame_cnt);
        end
    endtask

    task automatic test_tlast_bounds();
        int fires;
        int skew;
        bit seen;
        set_ramp();
        xlast_at = -1;
        ylast_at = -1;
        run_frame(2, 6, 0, 1'b0, fires, skew);
        wait_report(seen);
        compared++;
        if (seen !== 1'b1 || fires !== 8 || peak_bin !== 3'd6 ||
            peak_mag !== RES_W'(60) || frame_err !== 1'b1) begin
            mismatched++;
            $display("FAIL no_tlast: got n=%0d bin=%0d mag=%0d err=%0b want 8/6/60/1",
                     fires, peak_bin, peak_mag, frame_err);
        end
        ack_report();
        xlast_at = 3;
        ylast_at = 3;
        run_frame(0, 7, 0, 1'b0, fires, skew);
        wait_report(seen);
        compared++;
        if (seen !== 1'b1 || fires !== 4 || peak_bin !== 3'd3 ||
            peak_mag !== RES_W'(30) || frame_err !== 1'b1) begin
            mismatched++;
            $display("FAIL early_tlast: got n=%0d bin=%0d mag=%0d err=%0b want 4/3/30/1",
                     fires, peak_bin, peak_mag, frame_err);
        end
        ack_report();
    endtask

    task automatic test_reset_mid();
        int fires;
        int skew;
        bit seen;
        set_ramp();
        xlast_at = 7;
        ylast_at = 7;
        cfg_bin_lo = 3'd0;
        cfg_bin_hi = 3'd7;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_x_tvalid = 1'b1;
            s_y_tvalid = 1'b1;
            s_x_tdata  = x_word(k);
            s_y_tdata  = y_word(k);
            if (k < 4) begin
                @(posedge clk); #1;
            end
        end
        #2 reset_b = 1'b0;
        #1;
        compared++;
        if ({busy, peak_valid, mult_in_valid, peak_found, frame_err,
             s_x_tready, s_y_tready} !== 7'd0 || frame_cnt !== 16'd0 ||
            mult_x_data !== '0 || mult_y_data !== '0 ||
            peak_mag !== '0 || peak_bin !== '0) begin
            mismatched++;
            $display("FAIL reset_mid: got busy=%0b cnt=%0d mx=%h want 0/0/0",
                     busy, frame_cnt, mult_x_data);
        end
        s_x_tvalid = 1'b0;
        s_y_tvalid = 1'b0;
        @(posedge clk); #1;
        reset_b = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 7, 0, 1'b0, fires, skew);
        wait_report(seen);
        compared++;
        if (seen !== 1'b1 || peak_bin !== 3'd7 || peak_mag !== RES_W'(70) ||
            frame_err !== 1'b0) begin
            mismatched++;
            $display("FAIL after_reset: got bin=%0d mag=%0d err=%0b want 7/70/0",
                     peak_bin, peak_mag, frame_err);
        end
        ack_report();
        compared++;
        if (frame_cnt !== 16'd1) begin
            mismatched++;
            $display("FAIL after_reset_cnt: got %0d want 1", frame_cnt);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_tie();
        test_window();
        test_gaps();
        test_misalign();
        test_tlast_bounds();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
